// File: rtl/mdio_phy_responder_if.sv
// MDIO responder bus bundle: pad-side MDC/MDIO, link status input and the
// register-write / status strobes produced by the responder.
interface mdio_phy_responder_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic        link_up;
  logic        reg_wr_pulse;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        busy;
  logic        frame_err;

  // Responder side.
  modport slave (
    input  mdc, mdio_in, link_up,
    output mdio_out, mdio_oen, reg_wr_pulse, reg_wr_addr, reg_wr_data,
           busy, frame_err
  );

  // Manager / environment side.
  modport master (
    output mdc, mdio_in, link_up,
    input  mdio_out, mdio_oen, reg_wr_pulse, reg_wr_addr, reg_wr_data,
           busy, frame_err
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder emulating a PHY register set. MDC and MDIO are
// oversampled in the system clock domain; every frame action happens on the
// system clock following a detected (synchronised) MDC rising edge.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [15:0] PHY_ID1     = 16'h0022,
  parameter logic [15:0] PHY_ID2     = 16'h1622,
  parameter logic [15:0] CTRL_RST    = 16'h1140,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  c10_clk50m,
  input  logic                  c10_resetn,
  mdio_phy_responder_if.slave   bus
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_ST   = 4'd1,
    ST_OP1  = 4'd2,
    ST_OP2  = 4'd3,
    ST_PHY  = 4'd4,
    ST_REG  = 4'd5,
    ST_TA1  = 4'd6,
    ST_TA2  = 4'd7,
    ST_DATA = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0] mdc_sync_q;
  logic [SYNC_STAGES-1:0] mdio_sync_q;
  logic                   mdc_prev_q;
  logic                   mdc_s;
  logic                   mdio_s;
  logic                   rise_s;

  state_t      state_q,   state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        op_first_q, op_first_d;
  logic        rd_q,      rd_d;
  logic        match_q,   match_d;
  logic [3:0]  phy_sh_q,  phy_sh_d;
  logic [3:0]  reg_sh_q,  reg_sh_d;
  logic [4:0]  regad_q,   regad_d;
  logic [15:0] sh_q,      sh_d;
  logic        oen_q,     oen_d;
  logic        out_q,     out_d;
  logic        busy_q,    busy_d;
  logic        ferr_q,    ferr_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_en_s;

  logic [15:0] reg0_q;
  logic [15:0] regs_q [4:31];
  logic [4:0]  regad_sel_s;
  logic [15:0] rd_data_s;

  assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
  assign mdio_s = mdio_sync_q[SYNC_STAGES-1];
  assign rise_s = mdc_s & ~mdc_prev_q;

  // Synchronise pad inputs; reset to idle-high so no spurious rise after reset.
  always_ff @(posedge c10_clk50m or negedge c10_resetn) begin
    if (!c10_resetn) begin
      mdc_sync_q  <= {SYNC_STAGES{1'b1}};
      mdio_sync_q <= {SYNC_STAGES{1'b1}};
      mdc_prev_q  <= 1'b1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], bus.mdc};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], bus.mdio_in};
      mdc_prev_q  <= mdc_s;
    end
  end

  // Read-data snapshot source for the register address completing this rise.
  always_comb begin
    regad_sel_s = {reg_sh_q, mdio_s};
    case (regad_sel_s)
      5'd0:    rd_data_s = reg0_q;
      5'd1:    rd_data_s = 16'h7809 | {13'd0, bus.link_up, 2'd0};
      5'd2:    rd_data_s = PHY_ID1;
      5'd3:    rd_data_s = PHY_ID2;
      default: rd_data_s = regs_q[regad_sel_s];
    endcase
  end

  // Frame FSM next-state and output logic; advances only on a synchronised MDC rise.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_first_d = op_first_q;
    rd_d       = rd_q;
    match_d    = match_q;
    phy_sh_d   = phy_sh_q;
    reg_sh_d   = reg_sh_q;
    regad_d    = regad_q;
    sh_d       = sh_q;
    oen_d      = oen_q;
    out_d      = out_q;
    busy_d     = busy_q;
    ferr_d     = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_s    = 1'b0;
    if (rise_s) begin
      case (state_q)
        ST_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != 6'd32) begin
              pre_cnt_d = pre_cnt_q + 6'd1;
            end else begin
              pre_cnt_d = pre_cnt_q;
            end
          end else if (pre_cnt_q == 6'd32) begin
            // This zero is the first start bit.
            state_d   = ST_ST;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end
        ST_ST: begin
          if (mdio_s) begin
            state_d = ST_OP1;
          end else begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
          end
        end
        ST_OP1: begin
          op_first_d = mdio_s;
          state_d    = ST_OP2;
        end
        ST_OP2: begin
          bit_cnt_d = 4'd0;
          if (op_first_q && !mdio_s) begin
            rd_d    = 1'b1;
            state_d = ST_PHY;
          end else if (!op_first_q && mdio_s) begin
            rd_d    = 1'b0;
            state_d = ST_PHY;
          end else begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
          end
        end
        ST_PHY: begin
          if (bit_cnt_q == 4'd4) begin
            match_d   = ({phy_sh_q, mdio_s} == PHY_ADDR);
            busy_d    = ({phy_sh_q, mdio_s} == PHY_ADDR);
            bit_cnt_d = 4'd0;
            state_d   = ST_REG;
          end else begin
            phy_sh_d  = {phy_sh_q[2:0], mdio_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_REG: begin
          if (bit_cnt_q == 4'd4) begin
            regad_d   = regad_sel_s;
            sh_d      = rd_data_s;
            bit_cnt_d = 4'd0;
            state_d   = ST_TA1;
          end else begin
            reg_sh_d  = {reg_sh_q[2:0], mdio_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_TA1: begin
          if (rd_q) begin
            state_d = ST_TA2;
            if (match_q) begin
              oen_d = 1'b0;
              out_d = 1'b0;
            end else begin
              oen_d = 1'b1;
            end
          end else if (mdio_s) begin
            state_d = ST_TA2;
          end else begin
            // Malformed write turnaround; only report frames addressed to us.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ferr_d  = match_q;
          end
        end
        ST_TA2: begin
          bit_cnt_d = 4'd0;
          if (rd_q) begin
            state_d = ST_DATA;
            sh_d    = {sh_q[14:0], 1'b0};
            if (match_q) begin
              out_d = sh_q[15];
            end else begin
              out_d = 1'b1;
            end
          end else if (!mdio_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ferr_d  = match_q;
          end
        end
        ST_DATA: begin
          if (rd_q) begin
            if (bit_cnt_q == 4'd15) begin
              // data[0] is being sampled on this rise; release the pad.
              oen_d = 1'b1;
              out_d = 1'b1;
            end else if (match_q) begin
              out_d = sh_q[15];
              sh_d  = {sh_q[14:0], 1'b0};
            end else begin
              sh_d  = {sh_q[14:0], 1'b0};
            end
          end else begin
            sh_d = {sh_q[14:0], mdio_s};
          end
          if (bit_cnt_q == 4'd15) begin
            state_d   = ST_IDLE;
            pre_cnt_d = 6'd0;
            busy_d    = 1'b0;
            if (!rd_q && match_q) begin
              wr_en_s    = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = regad_q;
              wr_data_d  = {sh_q[14:0], mdio_s};
            end else begin
              wr_en_s    = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pre_cnt_d = 6'd0;
          oen_d     = 1'b1;
          out_d     = 1'b1;
          busy_d    = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame FSM state and registered pad / strobe outputs.
  always_ff @(posedge c10_clk50m or negedge c10_resetn) begin
    if (!c10_resetn) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= 6'd0;
      bit_cnt_q  <= 4'd0;
      op_first_q <= 1'b0;
      rd_q       <= 1'b0;
      match_q    <= 1'b0;
      phy_sh_q   <= 4'd0;
      reg_sh_q   <= 4'd0;
      regad_q    <= 5'd0;
      sh_q       <= 16'd0;
      oen_q      <= 1'b1;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_first_q <= op_first_d;
      rd_q       <= rd_d;
      match_q    <= match_d;
      phy_sh_q   <= phy_sh_d;
      reg_sh_q   <= reg_sh_d;
      regad_q    <= regad_d;
      sh_q       <= sh_d;
      oen_q      <= oen_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Emulated register file; reg0 bit15 restores every register and never sticks.
  always_ff @(posedge c10_clk50m or negedge c10_resetn) begin
    if (!c10_resetn) begin
      reg0_q <= CTRL_RST;
      for (int i = 4; i < 32; i++) begin
        regs_q[i] <= 16'd0;
      end
    end else if (wr_en_s) begin
      case (wr_addr_d)
        5'd0: begin
          if (wr_data_d[15]) begin
            reg0_q <= CTRL_RST;
            for (int i = 4; i < 32; i++) begin
              regs_q[i] <= 16'd0;
            end
          end else begin
            reg0_q <= wr_data_d;
          end
        end
        5'd1, 5'd2, 5'd3: begin
          reg0_q <= reg0_q;
        end
        default: begin
          regs_q[wr_addr_d] <= wr_data_d;
        end
      endcase
    end else begin
      reg0_q <= reg0_q;
    end
  end

  assign bus.mdio_out     = out_q;
  assign bus.mdio_oen     = oen_q;
  assign bus.busy         = busy_q;
  assign bus.frame_err    = ferr_q;
  assign bus.reg_wr_pulse = wr_pulse_q;
  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.reg_wr_data  = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: drives Clause-22 frames on MDC/MDIO,
// expected read data queued in a scoreboard and popped when a read completes.
module tb_mdio_phy_responder;

  localparam int HALF = 8;  // system clocks per MDC half period

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   oen_low_cnt = 0;
  int   busy_cnt    = 0;
  int   wr_pulse_cnt = 0;
  int   ferr_cnt    = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
  } sb_item_t;
  sb_item_t sb_q[$];

  mdio_phy_responder_if bus();

  mdio_phy_responder dut (
    .c10_clk50m (clk),
    .c10_resetn (rst_n),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  // Event monitors sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.mdio_oen === 1'b0) oen_low_cnt <= oen_low_cnt + 1;
    if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (bus.reg_wr_pulse === 1'b1) wr_pulse_cnt <= wr_pulse_cnt + 1;
    if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] data);
    sb_item_t it;
    it.tag  = tag;
    it.data = data;
    sb_q.push_back(it);
  endtask

  // One MDC period; returns pad outputs as seen just before the rising edge.
  task automatic mdc_cycle(input logic b, output logic o_out, output logic o_oen);
    bus.mdio_in = b;
    bus.mdc     = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    o_out   = bus.mdio_out;
    o_oen   = bus.mdio_oen;
    bus.mdc = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic o, e;
    for (int i = n - 1; i >= 0; i--) begin
      mdc_cycle(v[i], o, e);
    end
  endtask

  task automatic mdio_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'h5, 4);                 // ST=01 OP=01
    send_bits({27'd0, phy}, 5);
    send_bits({27'd0, ra}, 5);
    send_bits(32'h2, 2);                 // TA=10
    send_bits({16'd0, d}, 16);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Read frame; abort_bit >= 0 asserts reset just before that data bit.
  task automatic mdio_read(input logic [4:0] phy, input logic [4:0] ra,
                           input logic matched, input int abort_bit);
    logic o, e, ta_out, ta_oen;
    logic [15:0] got;
    int drive_bad, busy0, oen0;
    sb_item_t it;
    busy0 = busy_cnt;
    oen0  = oen_low_cnt;
    got   = 16'd0;
    drive_bad = 0;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'h6, 4);                 // ST=01 OP=10
    send_bits({27'd0, phy}, 5);
    send_bits({27'd0, ra}, 5);
    mdc_cycle(1'b1, o, e);               // TA1, manager releases the line
    mdc_cycle(1'b1, ta_out, ta_oen);     // TA2
    for (int i = 0; i < 16; i++) begin
      if (i == abort_bit) begin
        check("abort_drive_before", bus.mdio_oen, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_oen", bus.mdio_oen, 1'b1);
        check("abort_out", bus.mdio_out, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      mdc_cycle(1'b1, o, e);
      got[15-i] = o;
      if (e !== ~matched) drive_bad++;
    end
    repeat (4) @(posedge clk);
    #1;
    if (matched) begin
      check("ta2_out", ta_out, 1'b0);
      check("ta2_oen", ta_oen, 1'b0);
      check("data_drive", drive_bad, 0);
      check("oen_release", bus.mdio_oen, 1'b1);
      check("busy_seen", (busy_cnt - busy0) > 0, 1'b1);
      check("busy_end", bus.busy, 1'b0);
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check(it.tag, got, it.data);
      end
    end else begin
      check("mis_oen_low", oen_low_cnt - oen0, 0);
      check("mis_busy", busy_cnt - busy0, 0);
      check("mis_drive", drive_bad, 0);
    end
  endtask

  initial begin
    int w0, f0, o0, b0;
    bus.mdc     = 1'b1;
    bus.mdio_in = 1'b1;
    bus.link_up = 1'b0;
    rst_n       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_oen", bus.mdio_oen, 1'b1);
    check("rst_out", bus.mdio_out, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_wr_pulse", bus.reg_wr_pulse, 1'b0);
    check("rst_wr_addr", bus.reg_wr_addr, 5'd0);
    check("rst_wr_data", bus.reg_wr_data, 16'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Read PHY ID1.
    sb_push("rd_reg2", 16'h0022);
    mdio_read(5'd0, 5'd2, 1'b1, -1);

    // Write then read back a storage register.
    w0 = wr_pulse_cnt;
    mdio_write(5'd0, 5'd5, 16'hA55A);
    check("wr5_pulses", wr_pulse_cnt - w0, 1);
    check("wr5_addr", bus.reg_wr_addr, 5'd5);
    check("wr5_data", bus.reg_wr_data, 16'hA55A);
    sb_push("rd_reg5", 16'hA55A);
    mdio_read(5'd0, 5'd5, 1'b1, -1);

    // Top of the register map.
    mdio_write(5'd0, 5'd31, 16'hBEEF);
    sb_push("rd_reg31", 16'hBEEF);
    mdio_read(5'd0, 5'd31, 1'b1, -1);

    // Status register reflects link_up.
    bus.link_up = 1'b1;
    sb_push("rd_reg1_up", 16'h780D);
    mdio_read(5'd0, 5'd1, 1'b1, -1);
    bus.link_up = 1'b0;
    sb_push("rd_reg1_dn", 16'h7809);
    mdio_read(5'd0, 5'd1, 1'b1, -1);

    // Write to read-only ID register strobes but does not change it.
    w0 = wr_pulse_cnt;
    mdio_write(5'd0, 5'd3, 16'hFFFF);
    check("wr3_pulses", wr_pulse_cnt - w0, 1);
    check("wr3_addr", bus.reg_wr_addr, 5'd3);
    sb_push("rd_reg3", 16'h1622);
    mdio_read(5'd0, 5'd3, 1'b1, -1);

    // Address mismatch: read and write to PHY 3.
    mdio_read(5'd3, 5'd2, 1'b0, -1);
    w0 = wr_pulse_cnt;
    mdio_write(5'd3, 5'd5, 16'h0000);
    check("mis_wr_pulses", wr_pulse_cnt - w0, 0);
    check("mis_wr_addr_hold", bus.reg_wr_addr, 5'd3);
    sb_push("rd_reg5_kept", 16'hA55A);
    mdio_read(5'd0, 5'd5, 1'b1, -1);

    // Short preamble (31 ones) followed by a read frame: no response.
    o0 = oen_low_cnt; b0 = busy_cnt; f0 = ferr_cnt;
    send_bits(32'h7FFF_FFFF, 31);
    send_bits(32'h6, 4);
    send_bits(32'h0, 5);
    send_bits(32'h2, 5);
    send_bits(32'h3FFFF, 18);
    repeat (4) @(posedge clk);
    #1;
    check("short_pre_oen", oen_low_cnt - o0, 0);
    check("short_pre_busy", busy_cnt - b0, 0);
    check("short_pre_ferr", ferr_cnt - f0, 0);

    // OP=11 after a valid preamble.
    f0 = ferr_cnt;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'h7, 4);
    repeat (4) @(posedge clk);
    #1;
    check("op11_ferr", ferr_cnt - f0, 1);
    check("op11_busy", bus.busy, 1'b0);

    // Bad second start bit.
    f0 = ferr_cnt;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'h0, 2);
    repeat (4) @(posedge clk);
    #1;
    check("st_ferr", ferr_cnt - f0, 1);

    // Control register write, then self-clearing soft reset.
    mdio_write(5'd0, 5'd0, 16'h0100);
    sb_push("rd_reg0_wr", 16'h0100);
    mdio_read(5'd0, 5'd0, 1'b1, -1);
    mdio_write(5'd0, 5'd0, 16'h8000);
    sb_push("rd_reg0_srst", 16'h1140);
    mdio_read(5'd0, 5'd0, 1'b1, -1);
    sb_push("rd_reg5_srst", 16'h0000);
    mdio_read(5'd0, 5'd5, 1'b1, -1);
    sb_push("rd_reg31_srst", 16'h0000);
    mdio_read(5'd0, 5'd31, 1'b1, -1);

    // Hard reset in the middle of read data bit 7.
    mdio_write(5'd0, 5'd6, 16'h5AA5);
    mdio_read(5'd0, 5'd2, 1'b1, 7);
    sb_push("rd_reg6_after_rst", 16'h0000);
    mdio_read(5'd0, 5'd6, 1'b1, -1);
    sb_push("rd_reg2_after_rst", 16'h0022);
    mdio_read(5'd0, 5'd2, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
